// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit and the hazard
// unit's multdiv stall decode.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [4:0] ALU_MULT = 5'd6;
  localparam logic [4:0] ALU_DIV  = 5'd7;

  // A DX/XM stage holding a multdiv opcode stays frozen until the result is ready.
  function automatic logic holdStage(input logic [4:0] aluOp, input logic resultRdy);
    return ((aluOp == ALU_MULT) || (aluOp == ALU_DIV)) && !resultRdy;
  endfunction

endpackage

// File: rtl/multdiv_negate.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the result.
module multdiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] result_o
);

  assign result_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/multdiv_seq.sv
// Iterative signed multiply/divide, one bit per cycle on operand magnitudes.
// Optional overflow/divide-by-zero reporting under MULTDIV_EXCEPTION_EN.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   opA_q, opB_q;
  logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ready_q, busy_q;

  logic [WIDTH-1:0]   magA, magB, resultSigned;
  logic               resultNeg, divZero, firstStep, lastStep;
  logic [WIDTH-1:0]   hiIn, loIn, addend, diff;
  logic [WIDTH:0]     sum, shifted;

  assign resultNeg = opA_q[WIDTH-1] ^ opB_q[WIDTH-1];
  assign divZero   = (opB_q == '0);
  assign firstStep = (count_q == '0);

  multdiv_negate #(.WIDTH(WIDTH)) u_negA (
    .value_i (opA_q),
    .negate_i(opA_q[WIDTH-1]),
    .result_o(magA)
  );

  multdiv_negate #(.WIDTH(WIDTH)) u_negB (
    .value_i (opB_q),
    .negate_i(opB_q[WIDTH-1]),
    .result_o(magB)
  );

  // The first step loads the working registers straight from the latched
  // operand magnitudes, so no separate load cycle is needed.
  always_comb begin
    hiIn    = firstStep ? '0 : hi_q;
    loIn    = lo_q;
    if (firstStep) loIn = (state_q == DIV) ? magA : magB;
    addend  = loIn[0] ? magA : '0;
    sum     = {1'b0, hiIn} + {1'b0, addend};
    shifted = {hiIn, loIn[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - magB;
    if (state_q == DIV) begin
      if (shifted >= {1'b0, magB}) begin
        hi_d = diff;
        lo_d = {loIn[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {loIn[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], loIn[WIDTH-1:1]};
    end
  end

  multdiv_negate #(.WIDTH(WIDTH)) u_negResult (
    .value_i (lo_d),
    .negate_i(resultNeg),
    .result_o(resultSigned)
  );

  assign result_d = ((state_q == DIV) && divZero) ? '0 : resultSigned;

`ifdef MULTDIV_EXCEPTION_EN
  logic exception_q, exception_d, mulOverflow, divOverflow;

  // Product fits only if bits above the low word match its sign; a negative
  // product of exactly 2^(WIDTH-1) is still representable.
  assign mulOverflow = (|hi_d) | (lo_d[WIDTH-1] & (~resultNeg | (|lo_d[WIDTH-2:0])));
  assign divOverflow = (opA_q == {1'b1, {(WIDTH-1){1'b0}}}) && (&opB_q);
  assign exception_d = (state_q == DIV) ? (divZero | divOverflow) : mulOverflow;
  assign lastStep    = (count_q == CNT_W'(WIDTH-1)) || ((state_q == DIV) && divZero);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      exception_q <= 1'b0;
    end else if (((state_q == MULT) || (state_q == DIV)) && lastStep) begin
      exception_q <= exception_d;
    end
  end

  assign data_exception = exception_q;
`else
  assign lastStep       = (count_q == CNT_W'(WIDTH-1));
  assign data_exception = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      opA_q    <= '0;
      opB_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            opA_q   <= data_operandA;
            opB_q   <= data_operandB;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= ctrl_MULT ? MULT : DIV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        MULT, DIV: begin
          hi_q    <= hi_d;
          lo_q    <= lo_d;
          count_q <= count_q + CNT_W'(1);
          if (lastStep) begin
            result_q <= result_d;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_resultRDY = ready_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq; expectations follow
// MULTDIV_EXCEPTION_EN when it is defined.
module tb_multdiv_seq;

`ifdef MULTDIV_EXCEPTION_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int checkCount = 0;
  int passCount  = 0;
  int cycles, busyCycles;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
  endtask

  // Present a start pulse for exactly one rising edge; returns #1 after that edge.
  task automatic applyStimulus(input bit mult, input bit div, input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl_MULT     = mult;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Counts edges after the start edge until ready; optionally pulses a stray
  // ctrl_MULT at a given cycle to confirm it is ignored.
  task automatic waitReady(input int injectAt, output int nCycles, output int nBusy);
    nCycles = 0;
    nBusy   = 0;
    while (data_resultRDY !== 1'b1 && nCycles < 40) begin
      if (injectAt != 0 && nCycles == injectAt) begin
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
      end
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      nCycles++;
      if (data_resultRDY !== 1'b1 && busy === 1'b1) nBusy++;
    end
    if (nCycles >= 40) checkOutput("ready timeout", 32'(nCycles), 32'd32);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset exception", 32'(data_exception), 32'd0);
    checkOutput("reset ready", 32'(data_resultRDY), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // 7 * -6 = -42, started on the first edge after reset release
    applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    checkOutput("mul busy after start", 32'(busy), 32'd1);
    waitReady(0, cycles, busyCycles);
    checkOutput("mul latency", 32'(cycles), 32'd32);
    checkOutput("mul busy cycles", 32'(busyCycles), 32'd31);
    checkOutput("mul result", data_result, 32'hFFFF_FFD6);
    checkOutput("mul exception", 32'(data_exception), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("ready one cycle", 32'(data_resultRDY), 32'd0);
    checkOutput("result held", data_result, 32'hFFFF_FFD6);

    // -100 / 7 = -14 with a stray ctrl_MULT mid-operation
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    waitReady(10, cycles, busyCycles);
    checkOutput("div latency", 32'(cycles), 32'd32);
    checkOutput("div result", data_result, 32'hFFFF_FFF2);
    checkOutput("div exception", 32'(data_exception), 32'd0);

    // 0x10000 * 0x10000 overflows to 0
    applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    waitReady(0, cycles, busyCycles);
    checkOutput("mul ovf result", data_result, 32'd0);
    checkOutput("mul ovf exception", 32'(data_exception), 32'(EXC_EN));

    // -5 * -5 = 25, both starts high: multiply wins
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFB);
    waitReady(0, cycles, busyCycles);
    checkOutput("mul priority result", data_result, 32'd25);

    // Divide by zero
    applyStimulus(1'b0, 1'b1, 32'd123, 32'd0);
    waitReady(0, cycles, busyCycles);
    checkOutput("div0 latency", 32'(cycles), EXC_EN ? 32'd1 : 32'd32);
    checkOutput("div0 result", data_result, 32'd0);
    checkOutput("div0 exception", 32'(data_exception), 32'(EXC_EN));

    // Most-negative / -1 wraps to itself
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitReady(0, cycles, busyCycles);
    checkOutput("div min result", data_result, 32'h8000_0000);
    checkOutput("div min exception", 32'(data_exception), 32'(EXC_EN));

    // -7 / 2 truncates toward zero
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    waitReady(0, cycles, busyCycles);
    checkOutput("div trunc result", data_result, 32'hFFFF_FFFD);

    // Reset at iteration 15 aborts the operation
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort result", data_result, 32'd0);
    checkOutput("abort ready", 32'(data_resultRDY), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort exception", 32'(data_exception), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (20) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0) checkOutput("no ready after abort", 32'(data_resultRDY), 32'd0);
    end
    checkOutput("idle after abort", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd81, 32'd9);
    waitReady(0, cycles, busyCycles);
    checkOutput("div after reset latency", 32'(cycles), 32'd32);
    checkOutput("div after reset result", data_result, 32'd9);

    // Back-to-back multiply issued in the DONE cycle
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd5);
    waitReady(0, cycles, busyCycles);
    checkOutput("b2b first result", data_result, 32'd25);
    applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd4);
    checkOutput("b2b accepted busy", 32'(busy), 32'd1);
    checkOutput("b2b ready dropped", 32'(data_resultRDY), 32'd0);
    checkOutput("b2b result held", data_result, 32'd25);
    waitReady(0, cycles, busyCycles);
    checkOutput("b2b latency", 32'(cycles), 32'd32);
    checkOutput("b2b second result", data_result, 32'hFFFF_FFF4);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
MULTDIV_SEQ -- requirements
Module: multdiv_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port ctrl_MULT, input, 1 bit: one-cycle start pulse for a signed multiply.
REQ-005 The block SHALL have port ctrl_DIV, input, 1 bit: one-cycle start pulse for a signed divide.
REQ-006 The block SHALL have ports data_operandA and data_operandB, input, WIDTH bits each: multiplicand/dividend (A) and multiplier/divisor (B), sampled only on start.
REQ-007 The block SHALL have port data_result, output, WIDTH bits: registered result, held until the next accepted start.
REQ-008 The block SHALL have port data_exception, output, 1 bit: overflow or divide-by-zero, valid with data_resultRDY.
REQ-009 The block SHALL have port data_resultRDY, output, 1 bit: one-cycle completion pulse that releases the pipeline multdiv stall.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an operation is in flight.

Function
REQ-011 The block SHALL implement the states IDLE, MULT, DIV and DONE, plus a counter of clog2(WIDTH)+1 bits.
REQ-012 In IDLE or DONE, a start sampled high SHALL latch both operands, clear the counter and enter MULT or DIV; ctrl_MULT SHALL win when both starts are high.
REQ-013 A start arriving in MULT or DIV SHALL be ignored, with no effect on state, operands or result.
REQ-014 MULT SHALL perform one shift-add step per cycle on operand magnitudes; DIV SHALL perform one restoring shift-subtract step per cycle on operand magnitudes.
REQ-015 On the WIDTH-th iteration edge, the block SHALL register the sign-corrected result and enter DONE; data_resultRDY SHALL then be high for exactly the cycle WIDTH cycles after the start edge.
REQ-016 DONE SHALL return to IDLE on the next edge unless a new start is accepted.
REQ-017 busy SHALL be high in MULT and DIV and low in IDLE and DONE.
REQ-018 Multiply result SHALL be the low WIDTH bits of the signed 2*WIDTH product.
REQ-019 Divide result SHALL be the signed quotient truncated toward zero.
REQ-020 Divide of -2^(WIDTH-1) by -1 SHALL return -2^(WIDTH-1).
REQ-021 A divisor of 0 SHALL yield data_result = 0.
REQ-022 data_result SHALL change only on the edge that enters DONE.

Reset
REQ-023 While reset is high, the state SHALL be IDLE and the counter 0.
REQ-024 While reset is high, data_result, data_exception, data_resultRDY and busy SHALL all be 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no data_resultRDY pulse.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MULTDIV_EXCEPTION_EN defined: multiply SHALL set data_exception when the 2*WIDTH product is not the sign-extension of its low WIDTH bits.
REQ-028 Macro MULTDIV_EXCEPTION_EN defined: divide SHALL set data_exception when the divisor is 0 or on the -2^(WIDTH-1) / -1 case.
REQ-029 Macro MULTDIV_EXCEPTION_EN defined: a zero divisor SHALL go straight to DONE, so data_resultRDY rises 1 cycle after the start edge.
REQ-030 Macro MULTDIV_EXCEPTION_EN undefined: data_exception SHALL be tied 0, no detection logic SHALL exist, and a zero divisor SHALL take the full WIDTH cycles while still returning 0.

Structure
REQ-031 Shared package multdiv_pkg SHALL hold the state enum, ALU_MULT = 5'd6 and ALU_DIV = 5'd7, matching the hazard unit's multdiv opcode decode.
REQ-032 Two's-complement magnitude/negate logic SHALL live in one sub-module, multdiv_negate, instantiated for both operands and the result fix-up.
REQ-033 Each of the hazard unit's DX/XM stages SHALL stay held while its ALU opcode is ALU_MULT or ALU_DIV and data_resultRDY is low.

Verification
REQ-034 ctrl_MULT with A=7, B=-6 -> data_result=-42, data_exception=0, data_resultRDY high exactly 32 cycles after the start edge, busy high 31 cycles.
REQ-035 ctrl_DIV with A=-100, B=7 -> data_result=-14, data_exception=0; a ctrl_MULT pulsed mid-operation is ignored.
REQ-036 ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0, data_exception=1 with the macro defined, 0 without.
REQ-037 ctrl_DIV with B=0 -> data_result=0; with the macro defined, data_exception=1 and ready 1 cycle after start; without it, ready after 32 cycles.
REQ-038 Reset pulsed at iteration 15 -> all outputs 0, no data_resultRDY pulse; a following ctrl_DIV with A=81, B=9 -> data_result=9.
REQ-039 A new ctrl_MULT issued in the DONE cycle -> accepted back-to-back with no idle cycle, and the second data_resultRDY follows 32 cycles later.
